comm_master: RTL and testbench

Host-side command initiator for the logic-analyzer command channel. Accepts a 16-bit command word, serializes it over UART as two 8N1 frames (high byte first), and independently receives the 8-bit response byte returned by the capture unit's command/config responder. Sits in the host/test harness, driving the capture unit's RX line and listening on its TX line.

---
 rtl/comm_pkg.sv | 39 +++
 rtl/uart_tx.sv | 76 +++++++
 rtl/comm_master.sv | 181 ++++++++++++++++++
 tb/tb_comm_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the host-side command initiator.
// Opcode enum and command struct are also used by the test harness.
package comm_pkg;

    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SEND_HI = 2'b01,
        SEND_LO = 2'b10,
        DONE    = 2'b11
    } cmd_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_e;

    typedef enum logic [1:0] {
        ReadReg  = 2'b00,
        WriteReg = 2'b01,
        Dump     = 2'b10,
        Reserved = 2'b11
    } opcode_e;

    typedef struct packed {
        opcode_e    op;
        logic [5:0] addr;
        logic [7:0] data;
    } cmd_word_t;

    // 8N1 frame as shifted out LSB first: start 0, data, stop 1
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; tx_done pulses during the last clock of the stop bit
// so a new trmt in that cycle continues with no idle gap.
module uart_tx
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 1736
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       TX,
    output logic       tx_done
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  busy_q, busy_d;
    logic                  tx_done_q, tx_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        busy_d     = busy_q;
        tx_done_d  = 1'b0;

        if (trmt) begin
            shift_d    = make_frame(tx_data);
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            busy_d     = 1'b1;
        end else if (busy_q) begin
            if (baud_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                baud_cnt_d = '0;
                shift_d    = {1'b1, shift_q[FRAME_BITS-1:1]};
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
                    bit_cnt_d = '0;
                    busy_d    = 1'b0;
                end
            end else begin
                baud_cnt_d = baud_cnt_q + 1'b1;
                // Registered pulse lands on the final stop-bit clock
                if (baud_cnt_q == CNT_W'(BAUD_DIV - 2) &&
                    bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
                    tx_done_d = 1'b1;
                end
            end
        end
    end

    assign TX      = shift_q[0];
    assign tx_done = tx_done_q;

endmodule

// File: rtl/comm_master.sv
// Host command initiator: sends a 16-bit command as two UART bytes (high first)
// and independently receives single-byte responses.
module comm_master
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 1736
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_cmplt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);

    cmd_state_e  state_q, state_d;
    logic [15:0] held_q, held_d;
    logic        cmd_cmplt_q, cmd_cmplt_d;
    logic        trmt_c;
    logic [7:0]  tx_data_c;
    logic        accept_c;
    logic        tx_done;

    rx_state_e        rx_state_q, rx_state_d;
    logic             rx_ff1_q, rx_ff2_q, rx_prev_q;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       resp_q, resp_d;
    logic             resp_rdy_q, resp_rdy_d;
    logic             rx_set_c;

    uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data_c),
        .trmt    (trmt_c),
        .TX      (TX),
        .tx_done (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            held_q      <= '0;
            cmd_cmplt_q <= 1'b0;
            rx_state_q  <= RX_IDLE;
            rx_ff1_q    <= 1'b1;
            rx_ff2_q    <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            resp_q      <= '0;
            resp_rdy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            cmd_cmplt_q <= cmd_cmplt_d;
            rx_state_q  <= rx_state_d;
            rx_ff1_q    <= RX;
            rx_ff2_q    <= rx_ff1_q;
            rx_prev_q   <= rx_ff2_q;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            resp_q      <= resp_d;
            resp_rdy_q  <= resp_rdy_d;
        end
    end

    // Command FSM; the high byte is launched straight from cmd on acceptance
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        cmd_cmplt_d = cmd_cmplt_q;
        trmt_c      = 1'b0;
        tx_data_c   = held_q[15:8];
        accept_c    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (snd_cmd) begin
                    accept_c    = 1'b1;
                    held_d      = cmd;
                    cmd_cmplt_d = 1'b0;
                    trmt_c      = 1'b1;
                    tx_data_c   = cmd[15:8];
                    state_d     = SEND_HI;
                end
            end
            SEND_HI: begin
                if (tx_done) begin
                    trmt_c    = 1'b1;
                    tx_data_c = held_q[7:0];
                    state_d   = SEND_LO;
                end
            end
            SEND_LO: begin
                if (tx_done) begin
                    cmd_cmplt_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response receiver, armed by a falling edge of the synchronized line
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        resp_d     = resp_q;
        rx_set_c   = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_ff2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_W'(BAUD_DIV / 2 - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_ff2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_ff2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_ff2_q) begin
                        resp_d   = rx_shift_q;
                        rx_set_c = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // A fresh response outranks any clear in the same cycle
        if (rx_set_c) begin
            resp_rdy_d = 1'b1;
        end else if (clr_resp_rdy || accept_c) begin
            resp_rdy_d = 1'b0;
        end else begin
            resp_rdy_d = resp_rdy_q;
        end
    end

    assign cmd_cmplt = cmd_cmplt_q;
    assign resp      = resp_q;
    assign resp_rdy  = resp_rdy_q;

endmodule

// File: tb/tb_comm_master.sv
// Bench for comm_master: TX frames and responses are checked by monitors
// against expected-value queues filled when stimulus is issued.
module tb_comm_master;

    localparam int B = 16;

    logic        clk;
    logic        rst_n;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_cmplt;
    logic        TX;
    logic        RX;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy;

    int          n_vec;
    int          n_err;
    int unsigned rst_cnt;
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  resp_exp_q[$];

    comm_master #(.BAUD_DIV(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .snd_cmd      (snd_cmd),
        .cmd_cmplt    (cmd_cmplt),
        .TX           (TX),
        .RX           (RX),
        .resp         (resp),
        .resp_rdy     (resp_rdy),
        .clr_resp_rdy (clr_resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge rst_n) rst_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // TX monitor: decode each frame at bit centres and compare to expected bytes
    initial begin : tx_mon
        logic [7:0]  b;
        logic        start_bit;
        logic        stop_bit;
        int unsigned rc;
        forever begin
            @(negedge clk);
            if (rst_n && TX == 1'b0) begin
                rc = rst_cnt;
                repeat (B / 2 - 1) @(negedge clk);
                start_bit = TX;
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = TX;
                end
                repeat (B) @(negedge clk);
                stop_bit = TX;
                if (rc == rst_cnt) begin
                    if (tx_exp_q.size() == 0) begin
                        check("tx_unexpected", {22'd0, start_bit, stop_bit, b}, 32'hFFFF_FFFF);
                    end else begin
                        check("tx_frame", {22'd0, start_bit, stop_bit, b},
                              {22'd0, 1'b0, 1'b1, tx_exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Response monitor: every rising resp_rdy must present the next expected byte
    initial begin : resp_mon
        logic rdy_prev;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_rdy && !rdy_prev) begin
                if (resp_exp_q.size() == 0) begin
                    check("resp_unexpected", {24'd0, resp}, 32'hFFFF_FFFF);
                end else begin
                    check("resp_byte", {24'd0, resp}, {24'd0, resp_exp_q.pop_front()});
                end
            end
            rdy_prev = resp_rdy;
        end
    end

    task automatic send_cmd(input logic [15:0] c, input bit inject, input logic [15:0] junk);
        int k;
        bit done;
        tx_exp_q.push_back(c[15:8]);
        tx_exp_q.push_back(c[7:0]);
        @(negedge clk);
        cmd     = c;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd     = ~c;
        check("start_bit", {31'd0, TX}, 32'd0);
        check("cmplt_cleared", {31'd0, cmd_cmplt}, 32'd0);
        k    = 1;
        done = 1'b0;
        while (!done && k < 1000) begin
            if (inject && k == 100) begin
                cmd     = junk;
                snd_cmd = 1'b1;
            end
            if (inject && k == 101) snd_cmd = 1'b0;
            if (k == 200) check("cmplt_busy", {31'd0, cmd_cmplt}, 32'd0);
            @(negedge clk);
            k++;
            if (cmd_cmplt) done = 1'b1;
        end
        check("cmplt_cycle", k, 32'd321);
        check("tx_idle_at_cmplt", {31'd0, TX}, 32'd1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = stop_bit;
        repeat (B) @(negedge clk);
        RX = 1'b1;
    endtask

    initial begin : stim
        bit seen;
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        cmd          = '0;
        snd_cmd      = 1'b0;
        RX           = 1'b1;
        clr_resp_rdy = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, TX}, 32'd1);
        check("rst_cmplt", {31'd0, cmd_cmplt}, 32'd0);
        check("rst_resp", {24'd0, resp}, 32'd0);
        check("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Command with an ignored strobe mid-flight, then back-to-back command
        send_cmd(16'h4701, 1'b1, 16'h0800);
        send_cmd(16'h0800, 1'b0, 16'h0000);

        // Good response frame and explicit clear
        resp_exp_q.push_back(8'hAA);
        rx_frame(8'hAA, 1'b1);
        repeat (2) @(negedge clk);
        check("rdy_after_aa", {31'd0, resp_rdy}, 32'd1);
        check("resp_aa", {24'd0, resp}, 32'hAA);
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
        check("rdy_cleared", {31'd0, resp_rdy}, 32'd0);
        check("resp_held", {24'd0, resp}, 32'hAA);

        // Framing error is discarded
        rx_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_rdy", {31'd0, resp_rdy}, 32'd0);
        check("ferr_resp", {24'd0, resp}, 32'hAA);

        // Short low glitch is rejected
        @(negedge clk);
        RX = 1'b0;
        repeat (2) @(negedge clk);
        RX = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_rdy", {31'd0, resp_rdy}, 32'd0);
        check("glitch_resp", {24'd0, resp}, 32'hAA);

        // Clear held high while a good frame completes: set must win
        resp_exp_q.push_back(8'h3C);
        seen = 1'b0;
        clr_resp_rdy = 1'b1;
        fork
            rx_frame(8'h3C, 1'b1);
            begin
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clk);
                    if (resp_rdy) begin
                        seen         = 1'b1;
                        clr_resp_rdy = 1'b0;
                    end
                end
                clr_resp_rdy = 1'b0;
            end
        join
        check("set_over_clr_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        check("rdy_after_3c", {31'd0, resp_rdy}, 32'd1);
        check("resp_3c", {24'd0, resp}, 32'h3C);

        // Accepted command clears resp_rdy
        tx_exp_q.push_back(8'h81);
        tx_exp_q.push_back(8'h23);
        @(negedge clk);
        cmd     = 16'h8123;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        check("rdy_cleared_by_cmd", {31'd0, resp_rdy}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (cmd_cmplt) seen = 1'b1;
        end
        check("cmd_8123_done", {31'd0, seen}, 32'd1);

        // Reset in the middle of the high byte while TX is low
        resp_exp_q.push_back(8'h5A);
        fork
            rx_frame(8'h5A, 1'b1);
            begin
                repeat (100) @(negedge clk);
                cmd     = 16'hC3A5;
                snd_cmd = 1'b1;
                @(negedge clk);
                snd_cmd = 1'b0;
                repeat (80) @(negedge clk);
                check("pre_rst_tx_low", {31'd0, TX}, 32'd0);
                check("pre_rst_rdy", {31'd0, resp_rdy}, 32'd1);
                rst_n = 1'b0;
                #1;
                check("midrst_tx", {31'd0, TX}, 32'd1);
                check("midrst_cmplt", {31'd0, cmd_cmplt}, 32'd0);
                check("midrst_rdy", {31'd0, resp_rdy}, 32'd0);
                check("midrst_resp", {24'd0, resp}, 32'd0);
            end
        join
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        send_cmd(16'h5A0F, 1'b0, 16'h0000);

        repeat (50) @(negedge clk);
        check("tx_queue_empty", tx_exp_q.size(), 32'd0);
        check("resp_queue_empty", resp_exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
